// File: rtl/string_typewriter.sv
// Runtime-writable text overlay with a frame-paced typewriter reveal and an
// optional blink once the whole string is shown. Also contains the character
// renderer (draw_rect_char) and glyph ROM (font_rom) it drives.
//
// VGA bus layout: {vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0]}
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

// Glyph ROM: 8-pixel line of character {addr[10:4]} at line addr[3:0], one
// cycle of read latency. Codes up to 7'h20 (control codes, space, blank 7'h00)
// are empty; printable codes use a compact generated glyph set with empty top
// and bottom lines so adjacent rows stay separated.
module font_rom (
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  char_line_pixels
);
  logic [6:0] code;
  logic [3:0] line;
  logic [7:0] rom_d;

  assign code = addr[10:4];
  assign line = addr[3:0];

  // Glyph line generation
  always_comb begin
    rom_d = 8'h00;
    if (code > 7'h20 && line != 4'd0 && line != 4'd15) begin
      rom_d = {1'b1, code} ^ {line, line};
    end
  end

  // Synchronous read port
  always_ff @(posedge clk) begin
    char_line_pixels <= rom_d;
  end
endmodule

// Character-cell renderer: turns the incoming pixel position into a character
// coordinate and glyph line, then paints TEXT_COLOUR where the glyph bit is set.
// Two-cycle latency; the glyph lookup overlaps the first stage.
module draw_rect_char #(
  parameter int          TEXT_POS_X  = 0,
  parameter int          TEXT_POS_Y  = 0,
  parameter int          TEXT_SIZE_X = 1,
  parameter int          TEXT_SIZE_Y = 1,
  parameter int          FONT_SIZE   = 1,
  parameter logic [11:0] TEXT_COLOUR = 12'hFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     text_en,
  input  logic [`VGA_BUS_SIZE-1:0] vga_bus_in,
  output logic [`VGA_BUS_SIZE-1:0] vga_bus_out,
  input  logic [7:0]               char_pixels,
  output logic [7:0]               char_xy,
  output logic [3:0]               char_line
);
  localparam int SCALE = 2 ** (FONT_SIZE - 1);
  localparam int BOX_W = 8 * SCALE * TEXT_SIZE_X;
  localparam int BOX_H = 16 * SCALE * TEXT_SIZE_Y;

  logic [10:0] hcount, vcount, rel_x, rel_y;
  logic [6:0]  px_x;
  logic [7:0]  px_y;
  logic        in_box;
  logic        unused_rel;

  logic [`VGA_BUS_SIZE-1:0] bus_d1_q, bus_out_q;
  logic                     in_box_q;
  logic [2:0]               col_q;

  assign hcount = vga_bus_in[24:14];
  assign vcount = vga_bus_in[37:27];
  assign rel_x  = hcount - 11'(TEXT_POS_X);
  assign rel_y  = vcount - 11'(TEXT_POS_Y);
  // Dividing by the scale is a plain bit offset since scale is a power of two.
  assign px_x   = rel_x[FONT_SIZE-1 +: 7];
  assign px_y   = rel_y[FONT_SIZE-1 +: 8];
  assign unused_rel = ^{rel_x, rel_y};

  assign in_box = ({1'b0, hcount} >= 12'(TEXT_POS_X)) &&
                  ({1'b0, hcount} <  12'(TEXT_POS_X + BOX_W)) &&
                  ({1'b0, vcount} >= 12'(TEXT_POS_Y)) &&
                  ({1'b0, vcount} <  12'(TEXT_POS_Y + BOX_H));

  assign char_xy   = {px_x[6:3], px_y[7:4]};
  assign char_line = px_y[3:0];

  // Stage 1: hold the pixel while the glyph line is fetched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_d1_q <= '0;
      in_box_q <= 1'b0;
      col_q    <= 3'd0;
    end else begin
      bus_d1_q <= vga_bus_in;
      in_box_q <= in_box;
      col_q    <= px_x[2:0];
    end
  end

  // Stage 2: paint lit glyph pixels, otherwise pass the bus through
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_out_q <= '0;
    end else begin
      bus_out_q <= bus_d1_q;
      if (text_en && in_box_q && char_pixels[3'd7 - col_q]) begin
        bus_out_q[11:0] <= TEXT_COLOUR;
      end
    end
  end

  assign vga_bus_out = bus_out_q;
endmodule

module string_typewriter #(
  parameter int          TEXT_SIZE_X   = 7,
  parameter int          TEXT_SIZE_Y   = 1,
  parameter int          FONT_SIZE     = 3,
  parameter int          TEXT_POS_X    = 0,
  parameter int          TEXT_POS_Y    = 120,
  parameter logic [11:0] TEXT_COLOUR   = 12'h03A,
  parameter int          REVEAL_FRAMES = 4,
  parameter int          BLINK_FRAMES  = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     module_en,
  input  logic                     frame_tick,
  input  logic                     start,
  input  logic                     blink_en,
  input  logic                     wr_en,
  input  logic [7:0]               wr_addr,
  input  logic [6:0]               wr_char,
  input  logic [`VGA_BUS_SIZE-1:0] vga_bus_in,
  output logic [`VGA_BUS_SIZE-1:0] vga_bus_out,
  output logic [7:0]               reveal_count,
  output logic                     reveal_done
);
  // state   | meaning
  // IDLE    | nothing revealed, waiting for start
  // REVEAL  | one more character every REVEAL_FRAMES frame ticks
  // SHOW    | whole string revealed, optional blink
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REVEAL = 2'd1;
  localparam logic [1:0] ST_SHOW   = 2'd2;

  localparam int         N        = TEXT_SIZE_X * TEXT_SIZE_Y;
  localparam logic [7:0] N8       = 8'(N);
  localparam logic [7:0] REV_LAST = 8'(REVEAL_FRAMES - 1);
  localparam logic [7:0] BLK_LAST = 8'(BLINK_FRAMES - 1);

  logic [6:0] buf_q [N];

  logic [1:0] state_q, state_d;
  logic [7:0] reveal_count_q, reveal_count_d;
  logic [7:0] frame_div_q, frame_div_d;
  logic [7:0] blink_div_q, blink_div_d;
  logic       visible_q, visible_d;

  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic [6:0]  char_code;
  logic [6:0]  rd_char;
  logic [7:0]  rd_idx, wr_idx;
  logic        rd_ok, wr_ok;

  assign wr_ok  = ({1'b0, wr_addr[7:4]} < 5'(TEXT_SIZE_X)) &&
                  ({1'b0, wr_addr[3:0]} < 5'(TEXT_SIZE_Y));
  assign wr_idx = {4'd0, wr_addr[3:0]} * 8'(TEXT_SIZE_X) + {4'd0, wr_addr[7:4]};

  assign rd_ok  = ({1'b0, char_xy[7:4]} < 5'(TEXT_SIZE_X)) &&
                  ({1'b0, char_xy[3:0]} < 5'(TEXT_SIZE_Y));
  assign rd_idx = {4'd0, char_xy[3:0]} * 8'(TEXT_SIZE_X) + {4'd0, char_xy[7:4]};

  // Character buffer: reset to spaces, in-range writes only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) buf_q[i] <= 7'h20;
    end else if (wr_en && wr_ok) begin
      for (int i = 0; i < N; i++) begin
        if (wr_idx == 8'(i)) buf_q[i] <= wr_char;
      end
    end
  end

  // Buffer read by linear index
  always_comb begin
    rd_char = 7'h00;
    for (int i = 0; i < N; i++) begin
      if (rd_idx == 8'(i)) rd_char = buf_q[i];
    end
  end

  assign char_code = (rd_ok && (rd_idx < reveal_count_q) && visible_q) ? rd_char : 7'h00;

  // Reveal / blink sequencing; start overrides everything including a same-cycle tick
  always_comb begin
    state_d        = state_q;
    reveal_count_d = reveal_count_q;
    frame_div_d    = frame_div_q;
    blink_div_d    = blink_div_q;
    visible_d      = visible_q;
    if (start) begin
      state_d        = ST_REVEAL;
      reveal_count_d = 8'd0;
      frame_div_d    = 8'd0;
      blink_div_d    = 8'd0;
      visible_d      = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_REVEAL: begin
          if (frame_tick) begin
            if (frame_div_q == REV_LAST) begin
              frame_div_d    = 8'd0;
              reveal_count_d = reveal_count_q + 8'd1;
              if (reveal_count_q + 8'd1 == N8) state_d = ST_SHOW;
            end else begin
              frame_div_d = frame_div_q + 8'd1;
            end
          end
        end
        ST_SHOW: begin
          if (blink_en) begin
            if (frame_tick) begin
              if (blink_div_q == BLK_LAST) begin
                blink_div_d = 8'd0;
                visible_d   = ~visible_q;
              end else begin
                blink_div_d = blink_div_q + 8'd1;
              end
            end
          end else begin
            blink_div_d = 8'd0;
            visible_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      reveal_count_q <= 8'd0;
      frame_div_q    <= 8'd0;
      blink_div_q    <= 8'd0;
      visible_q      <= 1'b1;
    end else begin
      state_q        <= state_d;
      reveal_count_q <= reveal_count_d;
      frame_div_q    <= frame_div_d;
      blink_div_q    <= blink_div_d;
      visible_q      <= visible_d;
    end
  end

  assign reveal_count = reveal_count_q;
  assign reveal_done  = (state_q == ST_SHOW);

  font_rom u_font_rom (
    .clk              (clk),
    .addr             ({char_code, char_line}),
    .char_line_pixels (char_pixels)
  );

  draw_rect_char #(
    .TEXT_POS_X  (TEXT_POS_X),
    .TEXT_POS_Y  (TEXT_POS_Y),
    .TEXT_SIZE_X (TEXT_SIZE_X),
    .TEXT_SIZE_Y (TEXT_SIZE_Y),
    .FONT_SIZE   (FONT_SIZE),
    .TEXT_COLOUR (TEXT_COLOUR)
  ) u_draw_rect_char (
    .clk         (clk),
    .rst         (rst),
    .text_en     (module_en),
    .vga_bus_in  (vga_bus_in),
    .vga_bus_out (vga_bus_out),
    .char_pixels (char_pixels),
    .char_xy     (char_xy),
    .char_line   (char_line)
  );
endmodule

// File: tb/tb_string_typewriter.sv
// Bench for string_typewriter: directed walk through the reveal/blink/restart
// scenarios followed by randomized control traffic, with pixel scans compared
// against a tick-counting reference of the text overlay.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module tb_string_typewriter;
  localparam int          X   = 7;
  localparam int          Y   = 1;
  localparam int          FS  = 2;
  localparam int          S   = 2;
  localparam int          PX  = 16;
  localparam int          PY  = 8;
  localparam logic [11:0] COL = 12'hF0C;
  localparam int          RF  = 2;
  localparam int          BF  = 3;
  localparam int          N   = X * Y;
  localparam int          BW  = `VGA_BUS_SIZE;

  logic          clk = 1'b0;
  logic          rst, module_en, frame_tick, start, blink_en, wr_en;
  logic [7:0]    wr_addr;
  logic [6:0]    wr_char;
  logic [BW-1:0] vga_bus_in, vga_bus_out;
  logic [7:0]    reveal_count;
  logic          reveal_done;

  int n_cmp = 0;
  int n_bad = 0;

  // reference: ticks counted since start, ticks counted while blinking in SHOW
  int         m_started, m_ticks, m_btick;
  logic [6:0] mbuf [N];

  always #5 clk = ~clk;

  string_typewriter #(
    .TEXT_SIZE_X(X), .TEXT_SIZE_Y(Y), .FONT_SIZE(FS), .TEXT_POS_X(PX),
    .TEXT_POS_Y(PY), .TEXT_COLOUR(COL), .REVEAL_FRAMES(RF), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .module_en(module_en), .frame_tick(frame_tick),
    .start(start), .blink_en(blink_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_char(wr_char), .vga_bus_in(vga_bus_in), .vga_bus_out(vga_bus_out),
    .reveal_count(reveal_count), .reveal_done(reveal_done)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_reveal();
    int r;
    if (m_started == 0) return 0;
    r = m_ticks / RF;
    return (r > N) ? N : r;
  endfunction

  function automatic bit m_done();
    return (m_started != 0) && (m_ticks / RF >= N);
  endfunction

  function automatic bit m_visible();
    return ((m_btick / BF) % 2) == 0;
  endfunction

  function automatic logic [7:0] font(input logic [6:0] code, input int ln);
    logic [3:0] l;
    l = 4'(ln);
    if (code <= 7'h20 || ln == 0 || ln == 15) return 8'h00;
    return {1'b1, code} ^ {l, l};
  endfunction

  function automatic logic [BW-1:0] exp_bus(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic [6:0]    code;
    logic [7:0]    g;
    int h, v, cx, cy, bn, ln, idx;
    r = b;
    h = int'(b[24:14]);
    v = int'(b[37:27]);
    if (module_en && h >= PX && h < PX + 8*S*X && v >= PY && v < PY + 16*S*Y) begin
      cx   = (h - PX) / (8*S);
      bn   = ((h - PX) / S) % 8;
      cy   = (v - PY) / (16*S);
      ln   = ((v - PY) / S) % 16;
      idx  = cy * X + cx;
      code = (idx < m_reveal() && m_visible()) ? mbuf[idx] : 7'h00;
      g    = font(code, ln);
      if (g[7 - bn]) r[11:0] = COL;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_started = 0;
    m_ticks   = 0;
    m_btick   = 0;
    for (int i = 0; i < N; i++) mbuf[i] = 7'h20;
  endtask

  // one clock with the given pulses; reference updated for the same edge
  task automatic step(input bit st, input bit tk, input bit we,
                      input logic [7:0] addr, input logic [6:0] ch);
    int x, y;
    start = st; frame_tick = tk; wr_en = we; wr_addr = addr; wr_char = ch;
    @(posedge clk);
    #1;
    if (we) begin
      x = int'(addr[7:4]);
      y = int'(addr[3:0]);
      if (x < X && y < Y) mbuf[y * X + x] = ch;
    end
    if (st) begin
      m_started = 1; m_ticks = 0; m_btick = 0;
    end else if (m_started != 0) begin
      if (m_ticks / RF >= N) begin
        if (blink_en) begin
          if (tk) m_btick++;
        end else begin
          m_btick = 0;
        end
      end else if (tk) begin
        m_ticks++;
      end
    end
    start = 1'b0; frame_tick = 1'b0; wr_en = 1'b0;
    check_val("reveal_count", 64'(reveal_count), 64'(m_reveal()));
    check_val("reveal_done", 64'(reveal_done), 64'(m_done()));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 8'h00, 7'h00);
      step(0, 0, 0, 8'h00, 7'h00);
    end
  endtask

  // drive random pixels and compare the bus two edges later
  task automatic scan(input int m);
    logic [BW-1:0] q[$];
    logic [BW-1:0] b, e;
    int h, v;
    for (int i = 0; i <= m; i++) begin
      if (i < m) begin
        h = $urandom_range(0, 140);
        v = $urandom_range(0, 50);
        b = {11'(v), 2'($urandom_range(0, 3)), 11'(h), 2'($urandom_range(0, 3)),
             12'($urandom_range(0, 4095))};
        vga_bus_in = b;
        q.push_back(exp_bus(b));
      end
      @(posedge clk);
      #1;
      if (i >= 1) begin
        e = q.pop_front();
        check_val("pixel", 64'(vga_bus_out), 64'(e));
      end
    end
  endtask

  initial begin
    string      s;
    byte        bt;
    logic [7:0] ad;
    logic [6:0] ch;
    int         x, y;
    s = "SkyHop";
    rst = 1'b1; module_en = 1'b1; frame_tick = 1'b0; start = 1'b0; blink_en = 1'b0;
    wr_en = 1'b0; wr_addr = 8'h00; wr_char = 7'h00; vga_bus_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_reveal_count", 64'(reveal_count), 64'd0);
    check_val("rst_reveal_done", 64'(reveal_done), 64'd0);
    check_val("rst_bus_out", 64'(vga_bus_out), 64'd0);
    rst = 1'b0;

    // text written but never started: overlay stays transparent
    for (int i = 0; i < 6; i++) begin
      bt = s[i];
      step(0, 0, 1, {4'(i), 4'd0}, bt[6:0]);
    end
    ticks(3);
    scan(80);

    // reveal two characters, then the rest
    step(1, 0, 0, 8'h00, 7'h00);
    ticks(4);
    check_val("reveal_after_4", 64'(reveal_count), 64'd2);
    scan(120);
    ticks(10);
    check_val("reveal_after_14", 64'(reveal_count), 64'd7);
    check_val("done_after_14", 64'(reveal_done), 64'd1);
    scan(80);

    // blink: hidden after 3 ticks, back after 6, blink_en drop unhides at once
    blink_en = 1'b1;
    ticks(3);
    scan(80);
    ticks(3);
    scan(80);
    ticks(3);
    blink_en = 1'b0;
    step(0, 0, 0, 8'h00, 7'h00);
    scan(80);

    // restart coincident with a tick at reveal_count 4
    step(1, 0, 0, 8'h00, 7'h00);
    ticks(8);
    check_val("reveal_at_4", 64'(reveal_count), 64'd4);
    step(1, 1, 0, 8'h00, 7'h00);
    check_val("restart_count", 64'(reveal_count), 64'd0);
    ticks(1);
    check_val("restart_one_tick", 64'(reveal_count), 64'd0);
    ticks(1);
    check_val("restart_two_ticks", 64'(reveal_count), 64'd1);

    // out-of-range writes ignored, in-range write in SHOW visible
    step(0, 0, 1, 8'h70, 7'h51);
    step(0, 0, 1, 8'h01, 7'h51);
    ticks(12);
    step(0, 0, 1, 8'h30, 7'h5A);
    scan(150);

    // async reset in the middle of a reveal
    step(1, 0, 0, 8'h00, 7'h00);
    ticks(6);
    check_val("pre_rst_count", 64'(reveal_count), 64'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_val("arst_reveal_count", 64'(reveal_count), 64'd0);
    check_val("arst_reveal_done", 64'(reveal_done), 64'd0);
    check_val("arst_bus_out", 64'(vga_bus_out), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 0, 0, 8'h00, 7'h00);
    ticks(14);
    scan(100);

    // randomized control traffic
    for (int k = 0; k < 500; k++) begin
      x  = $urandom_range(0, 8);
      y  = $urandom_range(0, 1);
      ad = {4'(x), 4'(y)};
      ch = 7'($urandom_range(33, 126));
      if ($urandom_range(0, 29) == 0) blink_en = ~blink_en;
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0), ad, ch);
      if (k % 50 == 49) begin
        module_en = 1'($urandom_range(0, 3) != 0);
        step(0, 0, 0, 8'h00, 7'h00);
        scan(40);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
